// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
//
// Purpose : single home for the hazard FSM state type, the default widths
//           of the multi-cycle latency field and performance counters, and
//           the register-index width used by the operand comparators.
// Ports   : none (package).

package hazard_pkg;

    // Width of an architectural register index (RA1D/RA2D/WA3E).
    localparam int REG_W = 4;

    // Default width of the multi-cycle latency field (MultiCyclesE / McCnt).
    localparam int MC_W_DEF = 4;

    // Default width of the stall/flush performance counters.
    localparam int PERF_W_DEF = 16;

    // RUN    : normal issue; load-use stalls and branch flushes resolved here.
    // MCWAIT : a multi-cycle Execute op is draining; the front end is frozen.
    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_MCWAIT = 1'b1
    } hz_state_e;

    // True when a load in Execute writes a register that Decode reads.
    // All index bits are compared; register 0 gets no special treatment.
    function automatic logic load_use_hit(
        input logic             mem_to_reg,
        input logic [REG_W-1:0] ra1,
        input logic [REG_W-1:0] ra2,
        input logic [REG_W-1:0] wa3
    );
        return mem_to_reg && ((ra1 == wa3) || (ra2 == wa3));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for hazard performance counts
//
// Purpose : counts cycles on which inc is high; sticks at all-ones instead of
//           wrapping so a long run never reports a small, misleading value.
// Ports   : clk   - clock, all updates on posedge
//           reset - synchronous, active-high; clears the count
//           inc   - add one this cycle (ignored once saturated)
//           count - current count value

module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard controller: load-use, branch flush, multi-cycle stall
//
// Purpose : resolves Decode/Execute hazards for a 5-stage pipe. Stall and
//           flush controls are combinational so they act in the same cycle
//           the hazard is seen. A two-state FSM freezes the front end while a
//           multi-cycle Execute operation completes.
// Ports   : clk, reset                 - clock and synchronous active-high reset
//           RA1D, RA2D                 - Decode source register indices
//           WA3E, MemtoRegE            - Execute destination and load flag
//           BranchTakenE               - branch resolved taken in Execute
//           MultiStartE, MultiCyclesE  - start of a multi-cycle op and its total length
//           StallF, StallD, StallE     - hold PC, F/D pipe, D/E pipe
//           FlushD, FlushE             - clear F/D pipe, D/E pipe
//           BusyE                      - multi-cycle op in progress
//           StallCnt, FlushCnt         - saturating counts of StallD / FlushD cycles

module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MC_W   = MC_W_DEF,
    parameter int PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_W-1:0]  RA1D,
    input  logic [REG_W-1:0]  RA2D,
    input  logic [REG_W-1:0]  WA3E,
    input  logic              MemtoRegE,
    input  logic              BranchTakenE,
    input  logic              MultiStartE,
    input  logic [MC_W-1:0]   MultiCyclesE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              BusyE,
    output logic [PERF_W-1:0] StallCnt,
    output logic [PERF_W-1:0] FlushCnt
);

    hz_state_e        state_q;
    hz_state_e        state_d;
    logic [MC_W-1:0]  mc_cnt_q;
    logic [MC_W-1:0]  mc_cnt_d;

    logic load_use;
    logic multi_long;

    assign load_use   = load_use_hit(MemtoRegE, RA1D, RA2D, WA3E);
    // Latencies of 0 or 1 complete in the normal Execute slot; only >=2 needs MCWAIT.
    assign multi_long = MultiStartE && (MultiCyclesE >= MC_W'(2));

    // Next-state logic. The starting cycle itself is the op's first Execute
    // cycle, so MCWAIT must last N-1 cycles: load N-2 and leave after the
    // cycle that sees zero.
    always_comb begin
        state_d  = state_q;
        mc_cnt_d = mc_cnt_q;
        unique case (state_q)
            ST_RUN: begin
                // A taken branch does not cancel the op already in Execute.
                if (multi_long) begin
                    state_d  = ST_MCWAIT;
                    mc_cnt_d = MultiCyclesE - MC_W'(2);
                end
            end
            ST_MCWAIT: begin
                if (mc_cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    mc_cnt_d = mc_cnt_q - MC_W'(1);
                end
            end
            default: begin
                state_d  = ST_RUN;
                mc_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_RUN;
            mc_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            mc_cnt_q <= mc_cnt_d;
        end
    end

    // Output decode. Reset forces everything quiet so a reset taken during
    // MCWAIT cannot leak a stall into the cycle it is asserted.
    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        BusyE  = 1'b0;
        if (!reset) begin
            if (state_q == ST_MCWAIT) begin
                // Whole front end waits; nothing else in the pipe is allowed
                // to move, so branch/load-use requests are ignored here.
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                BusyE  = 1'b1;
            end else if (BranchTakenE) begin
                // Wrong-path instructions in Fetch/Decode are squashed; this
                // also covers any load-use the squashed instruction had.
                FlushD = 1'b1;
                FlushE = 1'b1;
            end else if (load_use) begin
                // Hold the consumer in Decode and insert a bubble into Execute.
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end
    end

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallD),
        .count (StallCnt)
    );

    sat_counter #(
        .WIDTH (PERF_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (FlushD),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  RA1D, RA2D, WA3E;
    logic        MemtoRegE, BranchTakenE, MultiStartE;
    logic [3:0]  MultiCyclesE;

    logic        StallF, StallD, StallE, FlushD, FlushE, BusyE;
    logic [15:0] StallCnt, FlushCnt;

    logic        s_StallF, s_StallD, s_StallE, s_FlushD, s_FlushE, s_BusyE;
    logic [3:0]  s_StallCnt, s_FlushCnt;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: remaining front-end stall cycles and raw event totals.
    int m_busy_left = 0;
    int m_stall = 0;
    int m_flush = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MC_W(4), .PERF_W(16)) dut (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
        .MultiStartE(MultiStartE), .MultiCyclesE(MultiCyclesE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .BusyE(BusyE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt)
    );

    hazard_ctrl #(.MC_W(4), .PERF_W(4)) dut_small (
        .clk(clk), .reset(reset), .RA1D(RA1D), .RA2D(RA2D), .WA3E(WA3E),
        .MemtoRegE(MemtoRegE), .BranchTakenE(BranchTakenE),
        .MultiStartE(MultiStartE), .MultiCyclesE(MultiCyclesE),
        .StallF(s_StallF), .StallD(s_StallD), .StallE(s_StallE),
        .FlushD(s_FlushD), .FlushE(s_FlushE), .BusyE(s_BusyE),
        .StallCnt(s_StallCnt), .FlushCnt(s_FlushCnt)
    );

    // {StallF, StallD, StallE, FlushD, FlushE, BusyE}
    function automatic logic [5:0] obs();
        return {StallF, StallD, StallE, FlushD, FlushE, BusyE};
    endfunction

    function automatic logic [5:0] exp_out();
        if (reset) return 6'b000000;
        if (m_busy_left > 0) return 6'b111001;
        if (BranchTakenE) return 6'b000110;
        if (MemtoRegE && ((RA1D == WA3E) || (RA2D == WA3E))) return 6'b110010;
        return 6'b000000;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Advance one clock, stepping the model from the inputs held this cycle.
    task automatic tick();
        logic [5:0] e;
        e = exp_out();
        @(posedge clk);
        if (reset) begin
            m_busy_left = 0;
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (e[4]) m_stall++;
            if (e[2]) m_flush++;
            if (m_busy_left > 0) m_busy_left--;
            else if (MultiStartE && MultiCyclesE >= 2) m_busy_left = int'(MultiCyclesE) - 1;
        end
        #1;
    endtask

    task automatic idle_inputs();
        RA1D = 4'd1; RA2D = 4'd2; WA3E = 4'd3;
        MemtoRegE = 1'b0; BranchTakenE = 1'b0;
        MultiStartE = 1'b0; MultiCyclesE = 4'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        MemtoRegE = 1'b1; RA1D = 4'd3; BranchTakenE = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b want %b", obs(), 6'b000000);
        end
        tick();
        idle_inputs();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (StallCnt !== 16'd0 || FlushCnt !== 16'd0 || obs() !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset_state: got stall=%0d flush=%0d out=%b want 0 0 000000",
                     StallCnt, FlushCnt, obs());
        end
    endtask

    task automatic test_load_use();
        do_reset();
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd9;
        #1;
        n_cmp++;
        if (obs() !== 6'b110010) begin
            n_fail++;
            $display("FAIL load_use_out: got %b want %b", obs(), 6'b110010);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (StallCnt !== 16'd1 || obs() !== 6'b000000) begin
            n_fail++;
            $display("FAIL load_use_cnt: got stall=%0d out=%b want 1 000000", StallCnt, obs());
        end
        // Register 0 is compared like any other index.
        MemtoRegE = 1'b1; WA3E = 4'd0; RA1D = 4'd0; RA2D = 4'd7;
        #1;
        n_cmp++;
        if (obs() !== 6'b110010) begin
            n_fail++;
            $display("FAIL load_use_r0: got %b want %b", obs(), 6'b110010);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch_load_use();
        do_reset();
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; BranchTakenE = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 6'b000110) begin
            n_fail++;
            $display("FAIL branch_out: got %b want %b", obs(), 6'b000110);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (FlushCnt !== 16'd1 || StallCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL branch_cnt: got flush=%0d stall=%0d want 1 0", FlushCnt, StallCnt);
        end
    endtask

    task automatic test_multicycle(input int n, input logic with_branch);
        int stalls;
        int want;
        int budget;
        do_reset();
        want = (n >= 2) ? n - 1 : 0;
        MultiStartE = 1'b1; MultiCyclesE = 4'(n); BranchTakenE = with_branch;
        #1;
        n_cmp++;
        if (obs() !== (with_branch ? 6'b000110 : 6'b000000)) begin
            n_fail++;
            $display("FAIL mc_start_n%0d: got %b want %b", n, obs(),
                     with_branch ? 6'b000110 : 6'b000000);
        end
        tick();
        idle_inputs();
        // Hazard requests during MCWAIT must be ignored.
        MemtoRegE = 1'b1; RA1D = 4'd3; BranchTakenE = with_branch;
        #1;
        stalls = 0;
        budget = 40;
        while (BusyE === 1'b1 && budget > 0) begin
            n_cmp++;
            if (obs() !== 6'b111001) begin
                n_fail++;
                $display("FAIL mc_wait_out_n%0d: got %b want %b", n, obs(), 6'b111001);
            end
            stalls++;
            budget--;
            tick();
        end
        idle_inputs();
        #1;
        n_cmp++;
        if (stalls !== want || budget == 0) begin
            n_fail++;
            $display("FAIL mc_len_n%0d: got %0d stall cycles want %0d", n, stalls, want);
        end
        n_cmp++;
        if (StallCnt !== 16'(want) || BusyE !== 1'b0) begin
            n_fail++;
            $display("FAIL mc_cnt_n%0d: got stall=%0d busy=%b want %0d 0", n, StallCnt, BusyE, want);
        end
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        MultiStartE = 1'b1; MultiCyclesE = 4'd6;
        tick();
        idle_inputs();
        tick();
        n_cmp++;
        if (obs() !== 6'b111001) begin
            n_fail++;
            $display("FAIL rst_mid_pre: got %b want %b", obs(), 6'b111001);
        end
        reset = 1'b1;
        #1;
        n_cmp++;
        if (obs() !== 6'b000000) begin
            n_fail++;
            $display("FAIL rst_mid_during: got %b want %b", obs(), 6'b000000);
        end
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (obs() !== 6'b000000 || StallCnt !== 16'd0 || FlushCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL rst_mid_after: got out=%b stall=%0d flush=%0d want 000000 0 0",
                     obs(), StallCnt, FlushCnt);
        end
        tick();
        n_cmp++;
        if (BusyE !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_run: got busy=%b want 0", BusyE);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        for (int i = 0; i < 20; i++) tick();
        #1;
        n_cmp++;
        if (s_StallCnt !== 4'd15 || StallCnt !== 16'd20) begin
            n_fail++;
            $display("FAIL saturation: got small=%0d wide=%0d want 15 20", s_StallCnt, StallCnt);
        end
        tick();
        tick();
        n_cmp++;
        if (s_StallCnt !== 4'd15) begin
            n_fail++;
            $display("FAIL saturation_hold: got %0d want 15", s_StallCnt);
        end
        idle_inputs();
    endtask

    task automatic test_random();
        logic [5:0] e;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            reset        = ($urandom_range(0, 99) < 2);
            RA1D         = 4'($urandom_range(0, 3));
            RA2D         = 4'($urandom_range(0, 3));
            WA3E         = 4'($urandom_range(0, 3));
            MemtoRegE    = $urandom_range(0, 1);
            BranchTakenE = ($urandom_range(0, 3) == 0);
            MultiStartE  = ($urandom_range(0, 9) == 0);
            MultiCyclesE = 4'($urandom_range(0, 15));
            #1;
            e = exp_out();
            n_cmp++;
            if (obs() !== e || StallCnt !== 16'(sat(m_stall, 65535)) ||
                FlushCnt !== 16'(sat(m_flush, 65535)) ||
                s_StallCnt !== 4'(sat(m_stall, 15)) || s_FlushCnt !== 4'(sat(m_flush, 15))) begin
                n_fail++;
                $display("FAIL random_cyc%0d: got out=%b cnt=%0d/%0d small=%0d/%0d want out=%b cnt=%0d/%0d small=%0d/%0d",
                         i, obs(), StallCnt, FlushCnt, s_StallCnt, s_FlushCnt,
                         e, sat(m_stall, 65535), sat(m_flush, 65535),
                         sat(m_stall, 15), sat(m_flush, 15));
            end
            tick();
        end
        reset = 1'b0;
        idle_inputs();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        #1;
        test_reset();
        test_load_use();
        test_branch_load_use();
        test_multicycle(4, 1'b0);
        test_multicycle(1, 1'b0);
        test_multicycle(0, 1'b0);
        test_multicycle(15, 1'b0);
        test_multicycle(2, 1'b0);
        test_multicycle(5, 1'b1);
        test_reset_mid_op();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_W, default 4, meaning the width of the multi-cycle latency field.
REQ-002 SHALL have parameter PERF_W, default 16, meaning the width of the performance counters.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its posedge.
REQ-004 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port RA1D, input, 4, Decode source register 1.
REQ-006 SHALL have port RA2D, input, 4, Decode source register 2.
REQ-007 SHALL have port WA3E, input, 4, Execute destination register.
REQ-008 SHALL have port MemtoRegE, input, 1, Execute instruction is a load.
REQ-009 SHALL have port BranchTakenE, input, 1, branch resolved taken in Execute.
REQ-010 SHALL have port MultiStartE, input, 1, Execute instruction starts a multi-cycle operation.
REQ-011 SHALL have port MultiCyclesE, input, MC_W, total Execute cycles of that operation.
REQ-012 SHALL have ports StallF, StallD, StallE, output, 1 each, hold the PC, Fetch/Decode pipe and Decode/Execute pipe.
REQ-013 SHALL have ports FlushD, FlushE, output, 1 each, clear the Fetch/Decode and Decode/Execute pipes.
REQ-014 SHALL have port BusyE, output, 1, a multi-cycle operation is in progress.
REQ-015 SHALL have ports StallCnt and FlushCnt, output, PERF_W each, performance counters.

Function
REQ-016 SHALL implement the two-state FSM RUN and MCWAIT, with a down-counter McCnt of width MC_W.
REQ-017 SHALL drive StallF/StallD/StallE/FlushD/FlushE/BusyE combinationally from the current state and inputs, so they take effect in the same cycle (zero latency).
REQ-018 SHALL define LoadUse as MemtoRegE & ((RA1D==WA3E) | (RA2D==WA3E)), comparing all 4 bits with no register-0 exemption.
REQ-019 In RUN with LoadUse and no BranchTakenE, SHALL assert StallF=StallD=FlushE=1 and FlushD=0.
REQ-020 In RUN with BranchTakenE, SHALL assert FlushD=FlushE=1 and StallF=StallD=0; the branch takes priority over LoadUse.
REQ-021 In RUN, when MultiStartE=1 and MultiCyclesE>=2, SHALL enter MCWAIT next cycle with McCnt=MultiCyclesE-2.
REQ-022 In RUN, MultiCyclesE of 0 or 1 SHALL be treated as a single-cycle operation: no state change.
REQ-023 When MultiStartE and BranchTakenE coincide, SHALL produce the branch flush outputs this cycle and still enter MCWAIT.
REQ-024 In MCWAIT, SHALL assert StallF=StallD=StallE=BusyE=1 and FlushD=FlushE=0, ignoring BranchTakenE, MultiStartE and LoadUse.
REQ-025 In MCWAIT, SHALL decrement McCnt each cycle, and return to RUN on the cycle after McCnt==0 is observed.
REQ-026 Outcome: an N-cycle operation stalls Fetch/Decode for exactly N-1 cycles; BusyE=0 in RUN.
REQ-027 SHALL increment StallCnt on every cycle StallD=1, saturating at all-ones with no wrap.
REQ-028 SHALL increment FlushCnt on every cycle FlushD=1, saturating at all-ones with no wrap.
REQ-029 SHALL never assert StallD and FlushD together; when a flush is needed, the flush wins.

Reset
REQ-030 On reset=1 at posedge, SHALL set state=RUN, McCnt=0, StallCnt=0 and FlushCnt=0.
REQ-031 While reset=1, SHALL drive all stall/flush outputs and BusyE to 0.
REQ-032 Reset during MCWAIT SHALL abort the operation with no residual stall on the following cycle.

Structure
REQ-033 SHALL take the state enum (RUN, MCWAIT), the MC_W and PERF_W defaults, and the register-index width from shared package hazard_pkg.
REQ-034 SHALL instantiate one sub-module, sat_counter (parameterised width, inc, reset), once each for StallCnt and FlushCnt.

Verification
REQ-035 Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1 for 1 cycle; StallCnt=1.
REQ-036 Branch plus load-use same cycle: BranchTakenE=1 -> FlushD=FlushE=1, StallD=0; FlushCnt=1; StallCnt unchanged.
REQ-037 Multi-cycle: MultiStartE=1, MultiCyclesE=4 -> StallF/D/E=1 and BusyE=1 for exactly 3 cycles, then RUN; StallCnt=3.
REQ-038 Boundary: MultiCyclesE=1 and MultiCyclesE=0 -> no stall; MultiCyclesE=15 -> 14 stall cycles.
REQ-039 Reset mid-operation: reset=1 on the 2nd MCWAIT cycle of a 6-cycle operation -> next cycle all outputs 0, state RUN, counters 0.
REQ-040 Saturation: PERF_W=4 with 20 load-use cycles -> StallCnt=15 and held there.
